// File: rtl/morse_game_pkg.sv
//------------------------------------------------------------------------------
// Module  : morse_game_pkg
// Brief   : Game-state encodings and shared constants for the Morse trainer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package morse_game_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_START       = 3'd0;
    localparam logic [STATE_W-1:0] ST_PRACTICE    = 3'd1;
    localparam logic [STATE_W-1:0] ST_PLAY        = 3'd2;
    localparam logic [STATE_W-1:0] ST_LEVEL_CLEAR = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE        = 3'd4;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

`default_nettype wire

// File: rtl/morse_idle_timer.sv
//------------------------------------------------------------------------------
// Module  : morse_idle_timer
// Brief   : Per-letter idle timer; expire is high on the last count of a period.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module morse_idle_timer #(
    parameter int TIMEOUT_CYC = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic expire
);

    generate
        if (TIMEOUT_CYC > 0) begin : g_timer
            localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

            logic [CW-1:0] r_count;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_count <= '0;
                end else if (clr || !en || (r_count == LAST)) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end

            // A clear in the expiry cycle (e.g. a new letter) cancels the timeout.
            assign expire = en && !clr && (r_count == LAST);
        end else begin : g_no_timer
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, reset, en, clr};
            assign expire    = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/morse_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : morse_game_ctrl
// Brief   : Game-flow controller: checks decoded letters against per-level words.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module morse_game_ctrl
    import morse_game_pkg::*;
#(
    parameter int NUM_LEVELS  = 3,
    parameter int LVL_W       = 3,
    parameter int IDX_W       = 4,
    parameter int CNT_W       = 5,
    parameter int TIMEOUT_CYC = 0,
    parameter int PRACTICE_EN = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dot_pulse,
    input  logic                 dash_pulse,
    input  logic                 menu_pulse,
    input  logic                 letter_valid,
    input  logic [7:0]           letter,
    input  logic [7:0]           tgt_char,
    input  logic [IDX_W:0]       tgt_len,
    output logic [LVL_W-1:0]     tgt_level,
    output logic [IDX_W-1:0]     tgt_idx,
    output logic [STATE_W-1:0]   game_state,
    output logic [CNT_W-1:0]     letter_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 level_done,
    output logic                 game_done
);

    localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

    logic [STATE_W-1:0] r_state,  w_state_nxt;
    logic [LVL_W-1:0]   r_level,  w_level_nxt;
    logic [IDX_W-1:0]   r_idx,    w_idx_nxt;
    logic [CNT_W-1:0]   r_lcnt,   w_lcnt_nxt;
    logic [CNT_W-1:0]   r_err,    w_err_nxt;
    logic               r_level_done;
    logic               r_game_done;

    logic               w_match;
    logic               w_last;
    logic               w_enter_play;
    logic               w_expire;
    logic [CNT_W-1:0]   w_err_inc;

    assign w_match   = (letter == tgt_char);
    assign w_last    = ({1'b0, r_idx} == (tgt_len - 1'b1));
    assign w_err_inc = (&r_err) ? r_err : (r_err + 1'b1);

    morse_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .en     (r_state == ST_PLAY),
        .clr    (letter_valid | menu_pulse | w_enter_play),
        .expire (w_expire)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_level_nxt  = r_level;
        w_idx_nxt    = r_idx;
        w_lcnt_nxt   = r_lcnt;
        w_err_nxt    = r_err;
        w_enter_play = 1'b0;

        if (menu_pulse) begin
            w_state_nxt = ST_START;
            w_level_nxt = '0;
            w_idx_nxt   = '0;
            w_lcnt_nxt  = '0;
            w_err_nxt   = '0;
        end else begin
            case (r_state)
                ST_START: begin
                    if (dot_pulse && (PRACTICE_EN != 0)) begin
                        w_state_nxt = ST_PRACTICE;
                    end else if (dash_pulse) begin
                        w_state_nxt  = ST_PLAY;
                        w_level_nxt  = '0;
                        w_idx_nxt    = '0;
                        w_enter_play = 1'b1;
                    end
                end
                ST_PRACTICE: begin
                    if (letter_valid) begin
                        w_lcnt_nxt = r_lcnt + 1'b1;
                    end
                end
                ST_PLAY: begin
                    // An empty target word clears the level without waiting for input.
                    if (tgt_len == '0) begin
                        w_state_nxt = ST_LEVEL_CLEAR;
                        w_idx_nxt   = '0;
                    end else if (letter_valid) begin
                        if (w_match && w_last) begin
                            w_state_nxt = ST_LEVEL_CLEAR;
                            w_idx_nxt   = '0;
                        end else if (w_match) begin
                            w_idx_nxt = r_idx + 1'b1;
                        end else begin
                            w_idx_nxt = '0;
                            w_err_nxt = w_err_inc;
                        end
                    end else if (w_expire) begin
                        w_idx_nxt = '0;
                        w_err_nxt = w_err_inc;
                    end
                end
                ST_LEVEL_CLEAR: begin
                    if (dash_pulse) begin
                        if (r_level == LAST_LEVEL) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt  = ST_PLAY;
                            w_level_nxt  = r_level + 1'b1;
                            w_enter_play = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_START;
            r_level      <= '0;
            r_idx        <= '0;
            r_lcnt       <= '0;
            r_err        <= '0;
            r_level_done <= 1'b0;
            r_game_done  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_level      <= w_level_nxt;
            r_idx        <= w_idx_nxt;
            r_lcnt       <= w_lcnt_nxt;
            r_err        <= w_err_nxt;
            r_level_done <= (w_state_nxt == ST_LEVEL_CLEAR);
            r_game_done  <= (w_state_nxt == ST_DONE) && (r_state != ST_DONE);
        end
    end

    assign game_state = r_state;
    assign tgt_level  = r_level;
    assign tgt_idx    = r_idx;
    assign letter_cnt = r_lcnt;
    assign err_cnt    = r_err;
    assign level_done = r_level_done;
    assign game_done  = r_game_done;

endmodule

`default_nettype wire

// File: tb/tb_morse_game_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_morse_game_ctrl
// Brief   : Scoreboard bench for morse_game_ctrl with a three-word target ROM.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_morse_game_ctrl;
    import morse_game_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dot = 1'b0, dash = 1'b0, menu = 1'b0, lval = 1'b0;
    logic [7:0] letter = 8'h00;
    logic [7:0] tgt_char;
    logic [4:0] tgt_len;
    logic [2:0] tgt_level;
    logic [3:0] tgt_idx;
    logic [2:0] game_state;
    logic [4:0] letter_cnt, err_cnt;
    logic       level_done, game_done;
    logic       zero_len = 1'b0;

    always #5 clk = ~clk;

    morse_game_ctrl #(
        .NUM_LEVELS (3), .LVL_W (3), .IDX_W (4), .CNT_W (5),
        .TIMEOUT_CYC(100), .PRACTICE_EN(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dot_pulse    (dot),
        .dash_pulse   (dash),
        .menu_pulse   (menu),
        .letter_valid (lval),
        .letter       (letter),
        .tgt_char     (tgt_char),
        .tgt_len      (tgt_len),
        .tgt_level    (tgt_level),
        .tgt_idx      (tgt_idx),
        .game_state   (game_state),
        .letter_cnt   (letter_cnt),
        .err_cnt      (err_cnt),
        .level_done   (level_done),
        .game_done    (game_done)
    );

    // Target ROM: level 0 "SOS", level 1 "HI", level 2 "E".
    always_comb begin
        tgt_char = ASCII_SPACE;
        tgt_len  = 5'd0;
        case (tgt_level)
            3'd0: begin
                tgt_len = 5'd3;
                if (tgt_idx == 4'd0 || tgt_idx == 4'd2) tgt_char = "S";
                else if (tgt_idx == 4'd1)               tgt_char = "O";
            end
            3'd1: begin
                tgt_len = 5'd2;
                if (tgt_idx == 4'd0)      tgt_char = "H";
                else if (tgt_idx == 4'd1) tgt_char = "I";
            end
            3'd2: begin
                tgt_len = 5'd1;
                if (tgt_idx == 4'd0) tgt_char = "E";
            end
            default: ;
        endcase
        if (zero_len) tgt_len = 5'd0;
    end

    // kind 0: output snapshot, 1: level_done rise count, 2: game_done count, 3: rebase counts
    typedef struct {
        string      name;
        int         kind;
        logic [2:0] st;
        logic [2:0] lvl;
        logic [3:0] idx;
        logic [4:0] err;
        logic [4:0] lcnt;
        logic       ld;
        logic       gd;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0, n_fail = 0;
    int   ld_rise = 0, gd_seen = 0, ld_base = 0, gd_base = 0;
    logic ld_prev = 1'b0;

    always @(negedge clk) begin
        if (level_done && !ld_prev) ld_rise = ld_rise + 1;
        ld_prev = level_done;
        if (game_done) gd_seen = gd_seen + 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0: begin
                    n_tests = n_tests + 1;
                    if ({game_state, tgt_level, tgt_idx, err_cnt, letter_cnt, level_done, game_done}
                        !== {e.st, e.lvl, e.idx, e.err, e.lcnt, e.ld, e.gd}) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: got st=%0d lvl=%0d idx=%0d err=%0d lcnt=%0d ld=%b gd=%b, expected st=%0d lvl=%0d idx=%0d err=%0d lcnt=%0d ld=%b gd=%b",
                                 e.name, game_state, tgt_level, tgt_idx, err_cnt, letter_cnt, level_done, game_done,
                                 e.st, e.lvl, e.idx, e.err, e.lcnt, e.ld, e.gd);
                    end
                end
                1: begin
                    n_tests = n_tests + 1;
                    if (ld_rise - ld_base != e.cnt) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: got %0d, expected %0d", e.name, ld_rise - ld_base, e.cnt);
                    end
                end
                2: begin
                    n_tests = n_tests + 1;
                    if (gd_seen - gd_base != e.cnt) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: got %0d, expected %0d", e.name, gd_seen - gd_base, e.cnt);
                    end
                end
                default: begin
                    ld_base = ld_rise;
                    gd_base = gd_seen;
                end
            endcase
        end
    end

    task automatic x(input string nm, input logic [2:0] st, input logic [2:0] lvl, input logic [3:0] idx,
                     input logic [4:0] err, input logic [4:0] lcnt, input logic ld, input logic gd);
        exp_t t;
        t.name = nm; t.kind = 0; t.st = st; t.lvl = lvl; t.idx = idx;
        t.err = err; t.lcnt = lcnt; t.ld = ld; t.gd = gd; t.cnt = 0;
        sb.push_back(t);
    endtask

    task automatic xk(input string nm, input int kind, input int cnt);
        exp_t t;
        t.name = nm; t.kind = kind; t.st = '0; t.lvl = '0; t.idx = '0;
        t.err = '0; t.lcnt = '0; t.ld = 1'b0; t.gd = 1'b0; t.cnt = cnt;
        sb.push_back(t);
    endtask

    task automatic step(input logic d, input logic da, input logic m, input logic lv, input logic [7:0] ch);
        @(negedge clk);
        dot = d; dash = da; menu = m; lval = lv; letter = ch;
        @(posedge clk);
        #1;
        dot = 1'b0; dash = 1'b0; menu = 1'b0; lval = 1'b0; letter = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic ltr(input logic [7:0] ch);
        step(1'b0, 1'b0, 1'b0, 1'b1, ch);
    endtask

    task automatic do_dash();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_menu();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(1);                                   x("reset_state", 0, 0, 0, 0, 0, 0, 0);

        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);       x("dot_dash_start", 1, 0, 0, 0, 0, 0, 0);
        repeat (31) ltr("A");                      x("lcnt_31", 1, 0, 0, 0, 31, 0, 0);
        ltr("A"); ltr("A");                        x("lcnt_wrap", 1, 0, 0, 0, 1, 0, 0);
        do_dash();                                 x("dash_in_practice", 1, 0, 0, 0, 1, 0, 0);
        do_menu();                                 x("menu_clear", 0, 0, 0, 0, 0, 0, 0);

        do_dash();                                 x("start_play", 2, 0, 0, 0, 0, 0, 0);
        ltr("S"); ltr("O");                        x("idx_2", 2, 0, 2, 0, 0, 0, 0);
        ltr("T");                                  x("mismatch", 2, 0, 0, 1, 0, 0, 0);
        ltr("S"); ltr("O"); ltr("S");              x("clear_l0", 3, 0, 0, 1, 0, 1, 0);
        ltr("X");                                  x("lc_ignore", 3, 0, 0, 1, 0, 1, 0);
        do_dash();                                 x("next_l1", 2, 1, 0, 1, 0, 0, 0);
        ltr("H"); ltr("I");                        x("clear_l1", 3, 1, 0, 1, 0, 1, 0);
        do_dash(); ltr("E");                       x("clear_l2", 3, 2, 0, 1, 0, 1, 0);
        do_dash();                                 x("done_entry", 4, 2, 0, 1, 0, 0, 1);
        ltr("E");                                  x("done_hold", 4, 2, 0, 1, 0, 0, 0);
        do_dash();                                 x("done_dash", 4, 2, 0, 1, 0, 0, 0);
        do_menu();                                 x("menu_from_done", 0, 0, 0, 0, 0, 0, 0);
        xk("rebase", 3, 0);

        do_dash(); ltr("S"); ltr("O"); ltr("S");
        do_dash(); ltr("H"); ltr("I");
        do_dash(); ltr("E");
        do_dash();                                 x("clean_done", 4, 2, 0, 0, 0, 0, 1);
        idle(1);                                   x("done_pulse_end", 4, 2, 0, 0, 0, 0, 0);
        xk("level_done_count", 1, 3);
        xk("game_done_count", 2, 1);

        do_menu(); do_dash(); ltr("Q");            x("play_mismatch", 2, 0, 0, 1, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, "Q");         x("menu_beats_letter", 0, 0, 0, 0, 0, 0, 0);

        do_dash(); ltr("S");                       x("to_start", 2, 0, 1, 0, 0, 0, 0);
        idle(99);                                  x("to_99_idle", 2, 0, 1, 0, 0, 0, 0);
        idle(1);                                   x("timeout", 2, 0, 0, 1, 0, 0, 0);
        idle(99); ltr("S");                        x("letter_beats_timeout", 2, 0, 1, 1, 0, 0, 0);
        idle(1);                                   x("no_late_timeout", 2, 0, 1, 1, 0, 0, 0);

        do_menu(); do_dash();
        repeat (31) ltr("Q");                      x("err_31", 2, 0, 0, 31, 0, 0, 0);
        repeat (9) ltr("Q");                       x("err_sat", 2, 0, 0, 31, 0, 0, 0);
        zero_len = 1'b1;
        idle(1);                                   x("zero_len_clear", 3, 0, 0, 31, 0, 1, 0);
        zero_len = 1'b0;

        do_menu(); do_dash(); ltr("S"); ltr("O"); ltr("S"); do_dash();
        ltr("Q"); ltr("H");                        x("pre_reset", 2, 1, 1, 1, 0, 0, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        x("async_reset", 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(1);                                   x("after_reset", 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
